// File: rtl/char_table_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : char_table_writer_pkg
//  Description : Shared constants, state encoding and field helpers for the
//                character overlay table writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package char_table_writer_pkg;

  // Pixel coordinate width and sensor active height used by the post5 path
  localparam int POSITION_WIDTH = 12;
  localparam int OV5640_Y       = 720;

  // Table geometry, fixed by the overlay bus width
  localparam int CHAR_SLOTS     = 16;

  // Item word field offsets
  localparam int ITEM_COL_LSB   = 26;
  localparam int ITEM_ROW_LSB   = 16;
  localparam int ITEM_AUX_LSB   = 0;

  // First x whose column code would wrap past 63
  localparam int CHAR_COL_MAX   = 1008;

  // Largest accepted y: below 1024 and no deeper than 128 rows above the bottom
  localparam int CHAR_ROW_LIM   = 1024;
  localparam int CHAR_ROW_MAX   = ((OV5640_Y - 128) < (CHAR_ROW_LIM - 1)) ?
                                  (OV5640_Y - 128) : (CHAR_ROW_LIM - 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_CLEAR  = 2'd2
  } ctw_state_t;

  // Column code: 16-pixel column index plus one so that zero means empty
  function automatic logic [5:0] col_code(input logic [9:0] x);
    return x[9:4] + 6'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/char_table_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : char_table_writer_if
//  Description : Detection record valid/ready stream into the table writer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface char_table_writer_if
  import char_table_writer_pkg::*;
#(
  parameter int P_W = POSITION_WIDTH
);
  logic           valid;
  logic           ready;
  logic [3:0]     label;
  logic [P_W-1:0] x;
  logic [P_W-1:0] y;
  logic [15:0]    aux;

  // Record producer (post-processing side)
  modport master (output valid, output label, output x, output y, output aux,
                  input  ready);

  // Record consumer (table writer side)
  modport slave  (input  valid, input  label, input  x, input  y, input  aux,
                  output ready);
endinterface
`default_nettype wire

// File: rtl/char_table_writer_item_pack.sv
`default_nettype none
// ============================================================================
//  Module      : char_item_pack
//  Description : Quantises a detection position into the 32-bit overlay item
//                word and flags whether the position is representable.
//  Revision    : 1.0 - initial release
// ============================================================================
module char_item_pack
  import char_table_writer_pkg::*;
#(
  parameter int P_W = POSITION_WIDTH
) (
  input  wire logic [P_W-1:0] i_x,
  input  wire logic [P_W-1:0] i_y,
  input  wire logic [15:0]    i_aux,
  output logic      [31:0]    o_item,
  output logic                o_in_range
);

  logic [31:0] w_x_ext;
  logic [31:0] w_y_ext;

  // Pack fields; range check is done on zero-extended coordinates so any P_W works
  always_comb begin
    w_x_ext    = 32'(i_x);
    w_y_ext    = 32'(i_y);
    o_in_range = (w_x_ext < 32'(CHAR_COL_MAX)) && (w_y_ext <= 32'(CHAR_ROW_MAX));
    o_item                         = '0;
    o_item[ITEM_COL_LSB +: 6]      = col_code(i_x[9:0]);
    o_item[ITEM_ROW_LSB +: 8]      = i_y[9:2];
    o_item[ITEM_AUX_LSB +: 16]     = i_aux;
  end

endmodule
`default_nettype wire

// File: rtl/char_table_writer.sv
`default_nettype none
// ============================================================================
//  Module      : char_table_writer
//  Description : Collects detection records into a shadow table during a frame
//                and publishes it to the overlay label/item buses at the frame
//                boundary. Empty frames keep the last table for a few frames
//                before blanking it.
//  Revision    : 1.0 - initial release
// ============================================================================
module char_table_writer
  import char_table_writer_pkg::*;
#(
  parameter int P_W     = POSITION_WIDTH,
  parameter int P_SLOTS = CHAR_SLOTS,
  parameter int P_HOLD  = 3
) (
  input  wire logic                   sys_clk,
  input  wire logic                   sys_rst_n,
  input  wire logic                   i_frame_start,
  char_table_writer_if.slave          det,
  output logic [4*P_SLOTS-1:0]        o_label,
  output logic [32*P_SLOTS-1:0]       o_item,
  output logic [4:0]                  o_count,
  output logic                        o_overflow,
  output logic                        o_commit
);

  localparam int                HOLD_W      = (P_HOLD > 1) ? $clog2(P_HOLD) : 1;
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(P_HOLD - 1);
  localparam logic [4:0]        C_FULL      = 5'(P_SLOTS);

  ctw_state_t        r_state;
  ctw_state_t        w_state_nxt;

  logic [3:0]        r_sh_label [P_SLOTS];
  logic [31:0]       r_sh_item  [P_SLOTS];
  logic [4:0]        r_wr_ptr;
  logic              r_sh_ovf;
  logic [HOLD_W-1:0] r_empty_cnt;

  logic              r_skid_full;
  logic [3:0]        r_skid_label;
  logic [31:0]       r_skid_item;

  logic [31:0]       w_item;
  logic              w_in_range;
  logic              w_ready;
  logic              w_frame_edge;
  logic              w_clear;
  logic              w_fire;
  logic              w_to_skid;
  logic              w_accept;
  logic              w_write;
  logic              w_drop_full;

  logic [4*P_SLOTS-1:0]  w_sh_label_flat;
  logic [32*P_SLOTS-1:0] w_sh_item_flat;

  char_item_pack #(
    .P_W        (P_W)
  ) u_pack (
    .i_x        (det.x),
    .i_y        (det.y),
    .i_aux      (det.aux),
    .o_item     (w_item),
    .o_in_range (w_in_range)
  );

  // Flatten the shadow arrays into bus layout for the publish copy
  generate
    for (genvar k = 0; k < P_SLOTS; k++) begin : g_flat
      assign w_sh_label_flat[4*k +: 4]   = r_sh_label[k];
      assign w_sh_item_flat[32*k +: 32]  = r_sh_item[k];
    end
  endgenerate

  // State register; reset parks in ST_CLEAR so filling starts one cycle after release
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_CLEAR;
    else            r_state <= w_state_nxt;
  end

  // Next-state and per-state control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = 1'b0;
    w_frame_edge = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_ready = 1'b1;
        if (i_frame_start) begin
          w_frame_edge = 1'b1;
          w_state_nxt  = ST_COMMIT;
        end
      end
      ST_COMMIT: w_state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        w_clear     = 1'b1;
        w_state_nxt = ST_FILL;
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  assign det.ready = w_ready;

  // Handshake classification; a record on the frame edge belongs to the next frame
  always_comb begin
    w_fire      = det.valid && w_ready;
    w_to_skid   = w_fire && i_frame_start && w_in_range;
    w_accept    = w_fire && !i_frame_start && w_in_range;
    w_write     = w_accept && (r_wr_ptr != C_FULL);
    w_drop_full = w_accept && (r_wr_ptr == C_FULL);
  end

  // Shadow table fill and per-frame clear (skid record lands in slot 0)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < P_SLOTS; i++) begin
        r_sh_label[i] <= '0;
        r_sh_item[i]  <= '0;
      end
      r_wr_ptr <= '0;
      r_sh_ovf <= 1'b0;
    end else if (w_clear) begin
      for (int i = 0; i < P_SLOTS; i++) begin
        r_sh_label[i] <= '0;
        r_sh_item[i]  <= '0;
      end
      r_sh_ovf <= 1'b0;
      if (r_skid_full) begin
        r_sh_label[0] <= r_skid_label;
        r_sh_item[0]  <= r_skid_item;
        r_wr_ptr      <= 5'd1;
      end else begin
        r_wr_ptr      <= 5'd0;
      end
    end else begin
      if (w_write) begin
        r_sh_label[r_wr_ptr[3:0]] <= det.label;
        r_sh_item[r_wr_ptr[3:0]]  <= w_item;
        r_wr_ptr                  <= r_wr_ptr + 5'd1;
      end
      if (w_drop_full) r_sh_ovf <= 1'b1;
    end
  end

  // One-entry skid holding the record that arrived with the frame pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_skid_full  <= 1'b0;
      r_skid_label <= '0;
      r_skid_item  <= '0;
    end else if (w_to_skid) begin
      r_skid_full  <= 1'b1;
      r_skid_label <= det.label;
      r_skid_item  <= w_item;
    end else if (w_clear) begin
      r_skid_full  <= 1'b0;
    end
  end

  // Publish decision is registered on the frame-pulse edge, so the buses
  // change one cycle after the pulse; ST_COMMIT is the cycle o_commit is high
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      o_label     <= '0;
      o_item      <= '0;
      o_count     <= '0;
      o_overflow  <= 1'b0;
      o_commit    <= 1'b0;
      r_empty_cnt <= '0;
    end else begin
      o_commit <= 1'b0;
      if (w_frame_edge) begin
        if (r_wr_ptr != 5'd0) begin
          o_label     <= w_sh_label_flat;
          o_item      <= w_sh_item_flat;
          o_count     <= r_wr_ptr;
          o_overflow  <= r_sh_ovf;
          o_commit    <= 1'b1;
          r_empty_cnt <= '0;
        end else if (r_empty_cnt < C_HOLD_LAST) begin
          r_empty_cnt <= r_empty_cnt + 1'b1;
        end else begin
          o_label     <= '0;
          o_item      <= '0;
          o_count     <= '0;
          o_overflow  <= 1'b0;
          o_commit    <= 1'b1;
          r_empty_cnt <= C_HOLD_LAST;
        end
      end
    end
  end

endmodule
`default_nettype wire
